// File: rtl/fxp_seq_divider.sv
// fxp_seq_divider
// Sequential fixed-point divider: quotient = (dividend << FRAC_BITS) / divisor,
// computed by non-restoring division with one quotient bit per clock.
// Result is truncated toward zero and saturated to WIDTH bits.
//
// Parameters
//   WIDTH      operand / quotient width (default 16)
//   FRAC_BITS  fractional bits of operands and result (default 8, Q8.8)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (aborts any operation)
//   in_valid     operands valid
//   in_ready     idle and accepting operands (registered)
//   dividend     numerator, sampled on the accept edge
//   divisor      denominator, sampled on the accept edge
//   out_valid    result valid, held until out_ready
//   out_ready    consumer accepts the result
//   quotient     truncated, saturated quotient
//   div_by_zero  divisor was zero
//   overflow     true quotient not representable, result saturated
//
// Build option
//   DIVIDER_SIGNED_EN  when defined, operands and quotient are two's
//                      complement; otherwise everything is unsigned.
module fxp_seq_divider #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] SMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [N-1:0]     POS_LIM = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0]     NEG_LIM = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [WIDTH-1:0] dvd_raw;
  logic [WIDTH-1:0] dvs_raw;
  logic [WIDTH-1:0] dvs_mag;
  // Shift register: dividend bits leave at the MSB while quotient bits
  // enter at the LSB, so after N steps it holds the quotient magnitude.
  logic [N-1:0]     dq;
  logic signed [WIDTH:0] r;
`ifdef DIVIDER_SIGNED_EN
  logic             neg;
`endif

  logic [WIDTH+1:0] r_sh;
  logic [N:0]       r_ext;
  logic [N:0]       dvs_ext;
  logic [N:0]       addend;
  logic [N:0]       sum;
  logic             sub;
  logic             qbit;
  logic             accept;

  // Absolute value; |min negative| wraps to the same bit pattern, which
  // read unsigned is exactly 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
`ifdef DIVIDER_SIGNED_EN
    return v[WIDTH-1] ? -v : v;
`else
    return v;
`endif
  endfunction

`ifdef DIVIDER_SIGNED_EN
  // Returns {overflow, quotient}: applies sign and clamps to signed range.
  function automatic logic [WIDTH:0] saturate(input logic [N-1:0] mag,
                                              input logic         ng);
    if (ng) begin
      if (mag > NEG_LIM) return {1'b1, SMIN};
      return {1'b0, -mag[WIDTH-1:0]};
    end
    if (mag > POS_LIM) return {1'b1, SMAX};
    return {1'b0, mag[WIDTH-1:0]};
  endfunction
`else
  // Returns {overflow, quotient}: clamps to the unsigned range.
  function automatic logic [WIDTH:0] saturate(input logic [N-1:0] mag);
    if (|mag[N-1:WIDTH]) return {1'b1, {WIDTH{1'b1}}};
    return {1'b0, mag[WIDTH-1:0]};
  endfunction
`endif

  assign accept = (state == IDLE) && in_valid && in_ready;

  // Non-restoring step. R is kept WIDTH+1 bits wide; the shifted value is
  // sign-extended into the N+1 bit adder. Carry-in 1 with inverted divisor
  // subtracts, carry-in 0 adds.
  assign r_sh    = {r, dq[N-1]};
  assign r_ext   = {{(N-WIDTH-1){r_sh[WIDTH+1]}}, r_sh};
  assign dvs_ext = {{(N+1-WIDTH){1'b0}}, dvs_mag};
  assign sub     = ~r[WIDTH];
  assign addend  = sub ? ~dvs_ext : dvs_ext;
  assign sum     = r_ext + addend + {{N{1'b0}}, sub};
  // The new R always fits in WIDTH+1 bits, so every adder bit from R's MSB
  // upward is a copy of the sign; the quotient bit is set when R >= 0.
  assign qbit    = ~(|sum[N:WIDTH]);

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            state    <= PREP;
          end else begin
            in_ready <= 1'b1;
          end
        end
        PREP: begin
          cnt <= '0;
          if (dvs_raw == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            quotient    <= dvd_raw[WIDTH-1] ? SMIN : SMAX;
`else
            quotient    <= {WIDTH{1'b1}};
`endif
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
`ifdef DIVIDER_SIGNED_EN
          {overflow, quotient} <= saturate(dq, neg);
`else
          {overflow, quotient} <= saturate(dq);
`endif
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers; contents are don't-care outside an operation.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (accept) begin
          dvd_raw <= dividend;
          dvs_raw <= divisor;
        end
      end
      PREP: begin
        dvs_mag <= magnitude(dvs_raw);
        dq      <= {magnitude(dvd_raw), {FRAC_BITS{1'b0}}};
        r       <= '0;
`ifdef DIVIDER_SIGNED_EN
        neg     <= dvd_raw[WIDTH-1] ^ dvs_raw[WIDTH-1];
`endif
      end
      ITER: begin
        r  <= sum[WIDTH:0];
        dq <= {dq[N-2:0], qbit};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fxp_seq_divider.sv
module tb_fxp_seq_divider;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int N     = WIDTH + FRAC;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic             div_by_zero;
  logic             overflow;

  typedef struct {
    logic [15:0] q;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fxp_seq_divider #(.WIDTH(WIDTH), .FRAC_BITS(FRAC)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {div_by_zero, overflow, quotient} from plain integer math.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] d);
    longint sa, sd, q;
`ifdef DIVIDER_SIGNED_EN
    sa = longint'($signed(a));
    sd = longint'($signed(d));
    if (sd == 0) return {2'b10, (sa < 0) ? 16'h8000 : 16'h7FFF};
    q = (sa * 256) / sd;
    if (q > 32767)  return {2'b01, 16'h7FFF};
    if (q < -32768) return {2'b01, 16'h8000};
`else
    sa = longint'({48'd0, a});
    sd = longint'({48'd0, d});
    if (sd == 0) return {2'b10, 16'hFFFF};
    q = (sa * 256) / sd;
    if (q > 65535) return {2'b01, 16'hFFFF};
`endif
    return {2'b00, q[15:0]};
  endfunction

  task automatic do_op(input logic [15:0] a, input logic [15:0] d, input int hold);
    logic [17:0] m;
    exp_t e, got;
    int lat, n;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    chk("ready_idle", {31'd0, in_ready}, 32'd1);
    m = model(a, d);
    e.q = m[15:0]; e.ovf = m[16]; e.dbz = m[17];
    sb.push_back(e);
    in_valid = 1'b1; dividend = a; divisor = d; out_ready = 1'b0;
    step();
    in_valid = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    chk("busy_ready", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      in_valid = 1'($urandom);
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, (d == 16'd0) ? 32'd1 : 32'(N + 2));
    chk("done_ready", {31'd0, in_ready}, 32'd0);
    chk("sb_depth", sb.size(), 32'd1);
    got = e;
    if (sb.size() > 0) got = sb.pop_front();
    chk("quotient", {16'd0, quotient}, {16'd0, got.q});
    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, got.dbz});
    chk("overflow", {31'd0, overflow}, {31'd0, got.ovf});
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_q", {16'd0, quotient}, {16'd0, got.q});
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_valid", {31'd0, out_valid}, 32'd0);
    chk("hs_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q", {16'd0, quotient}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    do_op(16'h0300, 16'h0200, 5);
    do_op(16'hFD00, 16'h0200, 0);
    do_op(16'hFF00, 16'h0300, 0);
    do_op(16'h0100, 16'h0300, 0);
    do_op(16'h7F00, 16'h0001, 2);
    do_op(16'h8000, 16'h0100, 0);
    do_op(16'h0100, 16'h0000, 3);
    do_op(16'hFF00, 16'h0000, 0);
    do_op(16'h0000, 16'h0000, 0);
    do_op(16'h1234, 16'h0567, 0);

    // Abort in the middle of the iteration phase.
    while (!in_ready) step();
    in_valid = 1'b1; dividend = 16'h0300; divisor = 16'h0200;
    step();
    in_valid = 1'b0;
    repeat (11) step();
    rst = 1'b1;
    step();
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_q", {16'd0, quotient}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("abort_ready_after", {31'd0, in_ready}, 32'd1);
    do_op(16'h0300, 16'h0200, 1);

    for (int k = 0; k < 4; k++) do_op(16'($urandom), 16'($urandom), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
